// File: rtl/ring_buffer_reader.sv
// Read side of a single-clock circular buffer: walks rd_ptr toward wr_ptr, issues
// registered-read RAM accesses and streams the words out through a 2-entry queue.
module ring_buffer_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ovf_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]            qcount_q, qcount_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  ovf_q, ovf_d;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  // Stream handshake: a word transfers on every edge where out_valid && out_ready;
  // while out_ready is low, out_valid and out_data stay put.
  assign out_valid     = (qcount_q != 2'd0);
  assign out_data      = head_q;
  assign rd_ptr        = rd_ptr_q;
  assign ram_rdaddress = rd_ptr_q[ADDR_WIDTH-1:0];
  assign level         = wr_ptr - rd_ptr_q;
  assign ovf_err       = ovf_q;
  assign pop           = out_valid && out_ready;

  // occ is the queue occupancy after this edge if nothing new is issued.
  assign occ   = {1'b0, qcount_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (level != '0) && !flush && (occ < 3'd2);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    qcount_d   = qcount_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    ovf_d      = ovf_q | (level > DEPTH);
    if (flush) begin
      rd_ptr_d = wr_ptr;
      qcount_d = 2'd0;
    end else begin
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      inflight_d = issue;
      qcount_d   = occ[1:0];
      if (pop && (qcount_q == 2'd2)) head_d = tail_q;
      // Returning data lands in whichever slot is the first free one after the pop.
      if (inflight_q) begin
        if ((qcount_q == 2'd0) || ((qcount_q == 2'd1) && pop)) head_d = ram_q;
        else tail_d = ram_q;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_ptr_q   <= '0;
      qcount_q   <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      qcount_q   <= qcount_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Directed bench for ring_buffer_reader with a behavioural registered-read RAM,
// an expected-word queue filled by the writer and drained by a stream monitor.
module tb_ring_buffer_reader;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_q = '0;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic          ovf_err;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ring_buffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .aclr(aclr), .wr_ptr(wr_ptr), .flush(flush),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q), .rd_ptr(rd_ptr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf_err(ovf_err)
  );

  // clock / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[ram_rdaddress];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    wr_ptr = wr_ptr + 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic pulse_reset();
    aclr = 1'b1;
    #1;
    aclr = 1'b0;
    wr_ptr = '0;
    exp_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk(name, {31'b0, out_valid}, 32'd1);
  endtask

  // scoreboard monitor: a transfer happens at the coming edge
  always @(negedge clk) begin
    if (!aclr && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got %h expected no word at %0t", out_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL stream_data: got %h expected %h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // reset state
    #1 aclr = 1'b1;
    #1;
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_addr", 32'(ram_rdaddress), 32'd0);
    chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
    step(2);
    aclr = 1'b0;
    step();

    // basic latency
    out_ready = 1'b1;
    write_word(32'hA000_0001);
    #1;
    chk("lat_addr", 32'(ram_rdaddress), 32'd0);
    chk("lat_level", 32'(level), 32'd1);
    step();
    chk("lat_rd_ptr", 32'(rd_ptr), 32'd1);
    chk("lat_level0", 32'(level), 32'd0);
    chk("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_n2_data", out_data, 32'hA000_0001);
    step();
    chk("lat_n3_valid", {31'b0, out_valid}, 32'd0);

    // full buffer and wrap
    out_ready = 1'b0;
    pulse_reset();
    step();
    for (int i = 0; i < 8; i++) write_word(32'h10 + i);
    #1;
    chk("full_level", 32'(level), 32'd8);
    wait_valid("full_first_valid");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_stream_valid", {31'b0, out_valid}, 32'd1);
      step();
    end
    chk("full_rd_ptr", 32'(rd_ptr), 32'h8);
    chk("full_no_ovf", {31'b0, ovf_err}, 32'd0);
    write_word(32'h18);
    step(4);
    chk("wrap_rd_ptr", 32'(rd_ptr), 32'h9);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(32'h20 + i);
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, 32'h20);
    end
    chk("bp_rd_ptr", 32'(rd_ptr), 32'd11);
    chk("bp_level", 32'(level), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_valid", {31'b0, out_valid}, 32'd1);
      step();
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_end_ptr", 32'(rd_ptr), 32'd14);

    // flush with a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(32'h30 + i);
    step(4);
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));
    chk("flush_level", 32'(level), 32'd0);
    step(3);
    write_word(32'h40);
    step(4);
    chk("flush_after_drained", 32'(exp_q.size()), 32'd0);

    // overflow
    out_ready = 1'b0;
    wr_ptr = rd_ptr + 4'd9;
    step();
    chk("ovf_set", {31'b0, ovf_err}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ovf_after_flush", {31'b0, ovf_err}, 32'd1);
    chk("ovf_flush_valid", {31'b0, out_valid}, 32'd0);
    aclr = 1'b1;
    #1;
    chk("ovf_clr", {31'b0, ovf_err}, 32'd0);
    chk("ovf_clr_ptr", 32'(rd_ptr), 32'd0);
    aclr = 1'b0;
    wr_ptr = '0;
    step();

    // asynchronous reset mid-stream
    write_word(32'h50);
    write_word(32'h51);
    wait_valid("async_pre_valid");
    chk("async_pre_data", out_data, 32'h50);
    #2 aclr = 1'b1;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_data", out_data, 32'd0);
    chk("async_rd_ptr", 32'(rd_ptr), 32'd0);
    exp_q.delete();
    step();
    aclr = 1'b0;
    wr_ptr = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
